// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for a shared-ALU MIPS-subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables and selects.
// It counts retired instructions and traps on opcodes that are not supported.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             stall_i,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             ir_write_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             alu_src_o,
  output logic [2:0]       alu_op_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             mem_to_reg_o,
  output logic [2:0]       state_o,
  output logic             instr_done_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_count_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_FN  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  // Opcodes this controller knows how to sequence; anything else traps.
  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_R, OP_ADDI, OP_SLTI, OP_BEQ, OP_BNE, OP_LW, OP_SW: ok = 1'b1;
      default:                                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t            state_r;
  state_t            next_state_s;
  logic [5:0]        op_r;
  logic              illegal_r;
  logic [CNT_W-1:0]  count_r;

  logic              pc_write_s;
  logic              pc_src_s;
  logic              ir_write_s;
  logic              reg_write_s;
  logic              reg_dst_s;
  logic              alu_src_s;
  logic [2:0]        alu_op_s;
  logic              mem_read_s;
  logic              mem_write_s;
  logic              mem_to_reg_s;
  logic              instr_done_s;

  // Next-state and control decode from the current state, latched opcode, zero and stall.
  always_comb begin
    next_state_s = state_r;
    pc_write_s   = 1'b0;
    pc_src_s     = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    reg_dst_s    = 1'b0;
    alu_src_s    = 1'b0;
    alu_op_s     = 3'b000;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    instr_done_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (stall_i) begin
          next_state_s = S_FETCH;
        end else begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          mem_read_s   = 1'b1;
          next_state_s = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_supported(opcode_i)) begin
          next_state_s = S_EXEC;
        end else begin
          next_state_s = S_TRAP;
        end
      end
      S_EXEC: begin
        case (op_r)
          OP_R: begin
            alu_op_s     = ALU_FN;
            next_state_s = S_WB;
          end
          OP_ADDI: begin
            alu_src_s    = 1'b1;
            alu_op_s     = ALU_ADD;
            next_state_s = S_WB;
          end
          OP_SLTI: begin
            alu_src_s    = 1'b1;
            alu_op_s     = ALU_SLT;
            next_state_s = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_s    = 1'b1;
            alu_op_s     = ALU_ADD;
            next_state_s = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            alu_op_s     = ALU_SUB;
            pc_src_s     = 1'b1;
            // Branch taken when zero matches the branch sense (beq: equal, bne: not equal).
            pc_write_s   = (op_r == OP_BEQ) ? zero_i : ~zero_i;
            instr_done_s = 1'b1;
            next_state_s = S_FETCH;
          end
          default: next_state_s = S_TRAP;
        endcase
      end
      S_MEM: begin
        case (op_r)
          OP_LW: begin
            mem_read_s = 1'b1;
            if (stall_i) begin
              next_state_s = S_MEM;
            end else begin
              next_state_s = S_WB;
            end
          end
          OP_SW: begin
            mem_write_s = 1'b1;
            if (stall_i) begin
              next_state_s = S_MEM;
            end else begin
              instr_done_s = 1'b1;
              next_state_s = S_FETCH;
            end
          end
          default: next_state_s = S_TRAP;
        endcase
      end
      S_WB: begin
        case (op_r)
          OP_R: begin
            reg_write_s  = 1'b1;
            reg_dst_s    = 1'b1;
            instr_done_s = 1'b1;
            next_state_s = S_FETCH;
          end
          OP_ADDI, OP_SLTI: begin
            reg_write_s  = 1'b1;
            instr_done_s = 1'b1;
            next_state_s = S_FETCH;
          end
          OP_LW: begin
            reg_write_s  = 1'b1;
            mem_to_reg_s = 1'b1;
            instr_done_s = 1'b1;
            next_state_s = S_FETCH;
          end
          default: next_state_s = S_TRAP;
        endcase
      end
      S_TRAP:  next_state_s = S_TRAP;
      default: next_state_s = S_TRAP;
    endcase
  end

  // State, latched opcode, sticky trap flag and retired-instruction counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= S_FETCH;
      op_r      <= 6'h00;
      illegal_r <= 1'b0;
      count_r   <= '0;
    end else begin
      state_r   <= next_state_s;
      illegal_r <= illegal_r | (next_state_s == S_TRAP);
      if (state_r == S_DECODE) begin
        op_r <= opcode_i;
      end else begin
        op_r <= op_r;
      end
      if (instr_done_s) begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end
  end

  // While reset is held every strobe is forced low, so nothing is written mid-reset.
  assign pc_write_o    = rst_i & pc_write_s;
  assign pc_src_o      = rst_i & pc_src_s;
  assign ir_write_o    = rst_i & ir_write_s;
  assign reg_write_o   = rst_i & reg_write_s;
  assign reg_dst_o     = rst_i & reg_dst_s;
  assign alu_src_o     = rst_i & alu_src_s;
  assign alu_op_o      = rst_i ? alu_op_s : 3'b000;
  assign mem_read_o    = rst_i & mem_read_s;
  assign mem_write_o   = rst_i & mem_write_s;
  assign mem_to_reg_o  = rst_i & mem_to_reg_s;
  assign instr_done_o  = rst_i & instr_done_s;
  assign illegal_o     = rst_i & illegal_r;
  assign state_o       = rst_i ? state_r : 3'd0;
  assign instr_count_o = rst_i ? count_r : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (CNT_W=4 so counter wrap is reachable quickly).
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic       zero_i;
  logic       stall_i;
  logic       pc_write_o, pc_src_o, ir_write_o, reg_write_o, reg_dst_o, alu_src_o;
  logic [2:0] alu_op_o;
  logic       mem_read_o, mem_write_o, mem_to_reg_o, instr_done_o, illegal_o;
  logic [2:0] state_o;
  logic [3:0] instr_count_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i), .stall_i(stall_i),
    .pc_write_o(pc_write_o), .pc_src_o(pc_src_o), .ir_write_o(ir_write_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .alu_src_o(alu_src_o),
    .alu_op_o(alu_op_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .state_o(state_o), .instr_done_o(instr_done_o),
    .illegal_o(illegal_o), .instr_count_o(instr_count_o)
  );

  // Output vector: {pc_write, pc_src, ir_write, reg_write, reg_dst, alu_src,
  //                 alu_op[2:0], mem_read, mem_write, mem_to_reg, instr_done, illegal}
  logic [13:0] outs;
  assign outs = {pc_write_o, pc_src_o, ir_write_o, reg_write_o, reg_dst_o, alu_src_o,
                 alu_op_o, mem_read_o, mem_write_o, mem_to_reg_o, instr_done_o, illegal_o};

  localparam logic [13:0] V_ZERO   = 14'b0_0_0_0_0_0_000_0_0_0_0_0;
  localparam logic [13:0] V_FETCH  = 14'b1_0_1_0_0_0_000_1_0_0_0_0;
  localparam logic [13:0] V_EX_R   = 14'b0_0_0_0_0_0_010_0_0_0_0_0;
  localparam logic [13:0] V_EX_ADD = 14'b0_0_0_0_0_1_000_0_0_0_0_0;
  localparam logic [13:0] V_EX_SLT = 14'b0_0_0_0_0_1_011_0_0_0_0_0;
  localparam logic [13:0] V_EX_BT  = 14'b1_1_0_0_0_0_001_0_0_0_1_0;
  localparam logic [13:0] V_EX_BN  = 14'b0_1_0_0_0_0_001_0_0_0_1_0;
  localparam logic [13:0] V_MEM_LW = 14'b0_0_0_0_0_0_000_1_0_0_0_0;
  localparam logic [13:0] V_MEM_SW = 14'b0_0_0_0_0_0_000_0_1_0_1_0;
  localparam logic [13:0] V_WB_R   = 14'b0_0_0_1_1_0_000_0_0_0_1_0;
  localparam logic [13:0] V_WB_I   = 14'b0_0_0_1_0_0_000_0_0_0_1_0;
  localparam logic [13:0] V_WB_LW  = 14'b0_0_0_1_0_0_000_0_0_1_1_0;
  localparam logic [13:0] V_TRAP   = 14'b0_0_0_0_0_0_000_0_0_0_0_1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock cycle: apply inputs, check state and outputs, advance past the next edge.
  task automatic cyc(input string tag, input logic [5:0] op, input logic z, input logic st,
                     input logic [2:0] es, input logic [13:0] ev);
    opcode_i = op;
    zero_i   = z;
    stall_i  = st;
    #1;
    check({tag, ".state"}, {29'd0, state_o}, {29'd0, es});
    check({tag, ".outs"},  {18'd0, outs},    {18'd0, ev});
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string tag, input logic [3:0] exp);
    check({tag, ".count"}, {28'd0, instr_count_o}, {28'd0, exp});
  endtask

  initial begin
    rst_i    = 1'b0;
    opcode_i = 6'h00;
    zero_i   = 1'b0;
    stall_i  = 1'b0;
    #2;
    check("reset.state", {29'd0, state_o}, 32'd0);
    check("reset.outs",  {18'd0, outs},    32'd0);
    check_count("reset", 4'd0);
    @(posedge clk);
    #1;
    check("reset_held.outs", {18'd0, outs}, 32'd0);
    rst_i = 1'b1;

    // R-type: 0,1,2,4
    cyc("r.f",  6'h00, 1'b0, 1'b0, 3'd0, V_FETCH);
    cyc("r.d",  6'h00, 1'b0, 1'b0, 3'd1, V_ZERO);
    cyc("r.e",  6'h00, 1'b0, 1'b0, 3'd2, V_EX_R);
    cyc("r.w",  6'h00, 1'b0, 1'b0, 3'd4, V_WB_R);
    check_count("r", 4'd1);

    // beq taken / not taken, bne inverse
    cyc("beq1.f", 6'h04, 1'b1, 1'b0, 3'd0, V_FETCH);
    cyc("beq1.d", 6'h04, 1'b1, 1'b0, 3'd1, V_ZERO);
    cyc("beq1.e", 6'h04, 1'b1, 1'b0, 3'd2, V_EX_BT);
    check_count("beq1", 4'd2);
    cyc("beq0.f", 6'h04, 1'b0, 1'b0, 3'd0, V_FETCH);
    cyc("beq0.d", 6'h04, 1'b0, 1'b0, 3'd1, V_ZERO);
    cyc("beq0.e", 6'h04, 1'b0, 1'b0, 3'd2, V_EX_BN);
    check_count("beq0", 4'd3);
    cyc("bne0.f", 6'h05, 1'b0, 1'b0, 3'd0, V_FETCH);
    cyc("bne0.d", 6'h05, 1'b0, 1'b0, 3'd1, V_ZERO);
    cyc("bne0.e", 6'h05, 1'b0, 1'b0, 3'd2, V_EX_BT);
    cyc("bne1.f", 6'h05, 1'b1, 1'b0, 3'd0, V_FETCH);
    cyc("bne1.d", 6'h05, 1'b1, 1'b0, 3'd1, V_ZERO);
    cyc("bne1.e", 6'h05, 1'b1, 1'b0, 3'd2, V_EX_BN);
    check_count("bne", 4'd5);

    // lw with a 2-cycle MEM stall: 7 cycles total
    cyc("lw.f",  6'h23, 1'b0, 1'b0, 3'd0, V_FETCH);
    cyc("lw.d",  6'h23, 1'b0, 1'b0, 3'd1, V_ZERO);
    cyc("lw.e",  6'h23, 1'b0, 1'b0, 3'd2, V_EX_ADD);
    cyc("lw.m0", 6'h23, 1'b0, 1'b1, 3'd3, V_MEM_LW);
    cyc("lw.m1", 6'h23, 1'b0, 1'b1, 3'd3, V_MEM_LW);
    cyc("lw.m2", 6'h23, 1'b0, 1'b0, 3'd3, V_MEM_LW);
    cyc("lw.w",  6'h23, 1'b0, 1'b0, 3'd4, V_WB_LW);
    check_count("lw", 4'd6);

    // sw: done in MEM, no register write
    cyc("sw.f", 6'h2B, 1'b0, 1'b0, 3'd0, V_FETCH);
    cyc("sw.d", 6'h2B, 1'b0, 1'b0, 3'd1, V_ZERO);
    cyc("sw.e", 6'h2B, 1'b0, 1'b0, 3'd2, V_EX_ADD);
    cyc("sw.m", 6'h2B, 1'b0, 1'b0, 3'd3, V_MEM_SW);
    check_count("sw", 4'd7);

    // slti
    cyc("slti.f", 6'h0A, 1'b0, 1'b0, 3'd0, V_FETCH);
    cyc("slti.d", 6'h0A, 1'b0, 1'b0, 3'd1, V_ZERO);
    cyc("slti.e", 6'h0A, 1'b0, 1'b0, 3'd2, V_EX_SLT);
    cyc("slti.w", 6'h0A, 1'b0, 1'b0, 3'd4, V_WB_I);
    check_count("slti", 4'd8);

    // FETCH stall then addi
    cyc("addi.fs", 6'h08, 1'b0, 1'b1, 3'd0, V_ZERO);
    cyc("addi.f",  6'h08, 1'b0, 1'b0, 3'd0, V_FETCH);
    cyc("addi.d",  6'h08, 1'b0, 1'b0, 3'd1, V_ZERO);
    cyc("addi.e",  6'h08, 1'b0, 1'b0, 3'd2, V_EX_ADD);
    cyc("addi.w",  6'h08, 1'b0, 1'b0, 3'd4, V_WB_I);
    check_count("addi", 4'd9);

    // 16 more addi: count passes 15 -> 0 and returns to 9
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_cnt;
      exp_cnt = 4'(9 + i + 1);
      cyc("loop.f", 6'h08, 1'b0, 1'b0, 3'd0, V_FETCH);
      cyc("loop.d", 6'h08, 1'b0, 1'b0, 3'd1, V_ZERO);
      cyc("loop.e", 6'h08, 1'b0, 1'b0, 3'd2, V_EX_ADD);
      cyc("loop.w", 6'h08, 1'b0, 1'b0, 3'd4, V_WB_I);
      check_count("loop", exp_cnt);
    end

    // Reset pulsed in EXEC of an R-type
    cyc("rst.f", 6'h00, 1'b0, 1'b0, 3'd0, V_FETCH);
    cyc("rst.d", 6'h00, 1'b0, 1'b0, 3'd1, V_ZERO);
    rst_i = 1'b0;
    #1;
    check("rst_exec.state", {29'd0, state_o}, 32'd0);
    check("rst_exec.outs",  {18'd0, outs},    32'd0);
    check_count("rst_exec", 4'd0);
    @(posedge clk);
    #1;
    check("rst_exec_edge.outs", {18'd0, outs}, 32'd0);
    rst_i = 1'b1;
    cyc("post.f", 6'h00, 1'b0, 1'b0, 3'd0, V_FETCH);
    cyc("post.d", 6'h00, 1'b0, 1'b0, 3'd1, V_ZERO);
    cyc("post.e", 6'h00, 1'b0, 1'b0, 3'd2, V_EX_R);
    cyc("post.w", 6'h00, 1'b0, 1'b0, 3'd4, V_WB_R);
    check_count("post", 4'd1);

    // Illegal opcode 0x3F traps and stays trapped
    cyc("ill.f",  6'h3F, 1'b0, 1'b0, 3'd0, V_FETCH);
    cyc("ill.d",  6'h3F, 1'b0, 1'b0, 3'd1, V_ZERO);
    cyc("ill.t0", 6'h00, 1'b0, 1'b0, 3'd7, V_TRAP);
    cyc("ill.t1", 6'h00, 1'b1, 1'b1, 3'd7, V_TRAP);
    cyc("ill.t2", 6'h00, 1'b0, 1'b0, 3'd7, V_TRAP);
    check_count("ill", 4'd1);
    rst_i = 1'b0;
    #1;
    check("ill_rst.illegal", {31'd0, illegal_o}, 32'd0);
    check("ill_rst.state",   {29'd0, state_o},   32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    cyc("final.f", 6'h00, 1'b0, 1'b0, 3'd0, V_FETCH);
    check_count("final", 4'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
